// File: rtl/conv_1x1_addr_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv_1x1_addr_gen_if : control, config and address bus of the 1x1  |
// | convolution address generator.               Revision 1.0          |
// +--------------------------------------------------------------------+
interface conv_1x1_addr_gen_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter int NUM_PE = 4
);
  logic              start;
  logic [CNT_W-1:0]  cfg_ch_words;
  logic [CNT_W-1:0]  cfg_num_filter;
  logic [CNT_W-1:0]  cfg_num_pixel;
  logic [ADDR_W-1:0] cfg_ifm_base;
  logic [ADDR_W-1:0] cfg_wgt_base;
  logic              mem_ready;
  logic [ADDR_W-1:0] addr_ifm;
  logic [ADDR_W-1:0] addr_weight;
  logic              addr_valid;
  logic [NUM_PE-1:0] PE_en;
  logic [NUM_PE-1:0] PE_finish;
  logic              busy;
  logic              done;

  modport master (
    output start, cfg_ch_words, cfg_num_filter, cfg_num_pixel,
           cfg_ifm_base, cfg_wgt_base, mem_ready,
    input  addr_ifm, addr_weight, addr_valid, PE_en, PE_finish, busy, done
  );

  modport slave (
    input  start, cfg_ch_words, cfg_num_filter, cfg_num_pixel,
           cfg_ifm_base, cfg_wgt_base, mem_ready,
    output addr_ifm, addr_weight, addr_valid, PE_en, PE_finish, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/conv_1x1_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv_1x1_addr_gen : walks pixel / filter-group / channel-word loops |
// | and emits IFM + weight byte addresses.       Revision 1.0          |
// +--------------------------------------------------------------------+
module conv_1x1_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter int NUM_PE = 4,
  parameter int BPW    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  conv_1x1_addr_gen_if.slave  bus
);

  localparam int                FW      = CNT_W + 1;
  localparam logic [ADDR_W-1:0] c_bpw   = ADDR_W'(BPW);
  localparam logic [FW-1:0]     c_num_pe = FW'(NUM_PE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]  r_ch_words, r_num_filter, r_num_pixel;
  logic [CNT_W-1:0]  r_c, r_p;
  logic [FW-1:0]     r_filt_base;
  logic [ADDR_W-1:0] r_wgt_base, r_addr_ifm, r_addr_wgt, r_pix_ifm;

  logic              w_cfg_zero, w_last_c, w_more_grp, w_more_pix;
  logic [NUM_PE-1:0] w_lane_mask;
  logic [ADDR_W-1:0] w_addr_ifm, w_addr_wgt;
  logic              w_addr_valid, w_busy, w_done;
  logic [NUM_PE-1:0] w_pe_en, w_pe_finish;

  assign w_cfg_zero = (bus.cfg_ch_words == '0) || (bus.cfg_num_filter == '0) ||
                      (bus.cfg_num_pixel == '0);
  assign w_last_c   = (r_c == r_ch_words - CNT_W'(1));
  assign w_more_grp = (r_filt_base + c_num_pe) < {1'b0, r_num_filter};
  assign w_more_pix = (r_p != r_num_pixel - CNT_W'(1));

  // Lane i of the current group is live while its filter index is in range.
  generate
    for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
      assign w_lane_mask[i] = (r_filt_base + FW'(i)) < {1'b0, r_num_filter};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_ifm   = '0;
    w_addr_wgt   = '0;
    w_addr_valid = 1'b0;
    w_pe_en      = '0;
    w_pe_finish  = '0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = w_cfg_zero ? DONE : FETCH;
        end
      end
      FETCH: begin
        w_addr_ifm   = r_addr_ifm;
        w_addr_wgt   = r_addr_wgt;
        w_addr_valid = 1'b1;
        w_pe_en      = w_lane_mask;
        w_busy       = 1'b1;
        if (bus.mem_ready && w_last_c) begin
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        w_pe_finish = w_lane_mask;
        w_busy      = 1'b1;
        w_state_nxt = (w_more_grp || w_more_pix) ? FETCH : DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Addresses advance incrementally; r_pix_ifm remembers the current pixel's
  // first IFM word so each filter group can rewind to it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch_words   <= '0;
      r_num_filter <= '0;
      r_num_pixel  <= '0;
      r_c          <= '0;
      r_p          <= '0;
      r_filt_base  <= '0;
      r_wgt_base   <= '0;
      r_addr_ifm   <= '0;
      r_addr_wgt   <= '0;
      r_pix_ifm    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_ch_words   <= bus.cfg_ch_words;
            r_num_filter <= bus.cfg_num_filter;
            r_num_pixel  <= bus.cfg_num_pixel;
            r_wgt_base   <= bus.cfg_wgt_base;
            r_addr_ifm   <= bus.cfg_ifm_base;
            r_pix_ifm    <= bus.cfg_ifm_base;
            r_addr_wgt   <= bus.cfg_wgt_base;
            r_c          <= '0;
            r_p          <= '0;
            r_filt_base  <= '0;
          end
        end
        FETCH: begin
          if (bus.mem_ready) begin
            r_addr_ifm <= r_addr_ifm + c_bpw;
            r_addr_wgt <= r_addr_wgt + c_bpw;
            r_c        <= w_last_c ? '0 : r_c + CNT_W'(1);
          end
        end
        FINISH: begin
          if (w_more_grp) begin
            r_filt_base <= r_filt_base + c_num_pe;
            r_addr_ifm  <= r_pix_ifm;
          end else begin
            r_filt_base <= '0;
            r_p         <= r_p + CNT_W'(1);
            r_pix_ifm   <= r_addr_ifm;
            r_addr_wgt  <= r_wgt_base;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.addr_ifm    = w_addr_ifm;
  assign bus.addr_weight = w_addr_wgt;
  assign bus.addr_valid  = w_addr_valid;
  assign bus.PE_en       = w_pe_en;
  assign bus.PE_finish   = w_pe_finish;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_1x1_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_conv_1x1_addr_gen : directed bench for conv_1x1_addr_gen.        |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_conv_1x1_addr_gen;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;
  localparam int NUM_PE = 4;
  localparam int BPW    = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  conv_1x1_addr_gen_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .NUM_PE(NUM_PE)) ifc ();

  conv_1x1_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .NUM_PE(NUM_PE), .BPW(BPW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] acc_ifm[$], acc_wgt[$], stl_ifm[$], stl_wgt[$];
  logic [3:0]  acc_pe[$], fin_q[$], stl_pe[$];
  int          done_cyc, n_busy;
  bit          valid_seen;

  // Starts a layer, then records every accepted address pair, every stalled
  // pair, every PE_finish pulse and the cycle (start = cycle 0) of done.
  task automatic run_layer(input logic [15:0] ch, input logic [15:0] nf, input logic [15:0] np,
                           input logic [31:0] ib, input logic [31:0] wb,
                           input int stall_at, input int stall_len, input int restart_cyc,
                           input int max_cyc);
    int n_acc = 0;
    int left  = stall_len;
    acc_ifm.delete(); acc_wgt.delete(); acc_pe.delete(); fin_q.delete();
    stl_ifm.delete(); stl_wgt.delete(); stl_pe.delete();
    done_cyc = -1; n_busy = 0; valid_seen = 0;
    ifc.cfg_ch_words = ch; ifc.cfg_num_filter = nf; ifc.cfg_num_pixel = np;
    ifc.cfg_ifm_base = ib; ifc.cfg_wgt_base = wb;
    ifc.mem_ready = 1'b1; ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.cfg_ch_words = 16'd3; ifc.cfg_num_filter = 16'd9; ifc.cfg_num_pixel = 16'd5;
    ifc.cfg_ifm_base = 32'hDEAD_0000; ifc.cfg_wgt_base = 32'hBEEF_0000;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      ifc.start = (cyc == restart_cyc);
      if (ifc.addr_valid && n_acc == stall_at && left > 0) begin
        ifc.mem_ready = 1'b0;
        left--;
        stl_ifm.push_back(ifc.addr_ifm); stl_wgt.push_back(ifc.addr_weight);
        stl_pe.push_back(ifc.PE_en);
      end else begin
        ifc.mem_ready = 1'b1;
      end
      if (ifc.addr_valid) valid_seen = 1;
      if (ifc.busy) n_busy++;
      if (ifc.addr_valid && ifc.mem_ready) begin
        acc_ifm.push_back(ifc.addr_ifm); acc_wgt.push_back(ifc.addr_weight);
        acc_pe.push_back(ifc.PE_en);
        n_acc++;
      end
      if (ifc.PE_finish != 4'd0) fin_q.push_back(ifc.PE_finish);
      if (ifc.done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    ifc.start = 1'b0; ifc.mem_ready = 1'b1;
    if (done_cyc < 0) begin
      reset_n = 1'b0; #1; reset_n = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ifc.start = 1'b0; ifc.mem_ready = 1'b1;
    ifc.cfg_ch_words = '0; ifc.cfg_num_filter = '0; ifc.cfg_num_pixel = '0;
    ifc.cfg_ifm_base = '0; ifc.cfg_wgt_base = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({ifc.addr_ifm, ifc.addr_weight, ifc.addr_valid, ifc.PE_en, ifc.PE_finish,
         ifc.busy, ifc.done} !== 79'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got ifm=%h wgt=%h v=%b en=%b fin=%b busy=%b done=%b, want all 0",
               ifc.addr_ifm, ifc.addr_weight, ifc.addr_valid, ifc.PE_en, ifc.PE_finish,
               ifc.busy, ifc.done);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (ifc.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_idle_busy: got %b want 0", ifc.busy);
    end
  endtask

  task automatic test_basic();
    logic [31:0] e_ifm[4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [31:0] e_wgt[4] = '{32'h800, 32'h804, 32'h800, 32'h804};
    run_layer(16'd2, 16'd4, 16'd2, 32'h100, 32'h800, -1, 0, -1, 40);
    n_vec++;
    if (acc_ifm.size() !== 4) begin
      n_err++; $display("FAIL basic_count: got %0d want 4", acc_ifm.size());
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] gi = (i < acc_ifm.size()) ? acc_ifm[i] : 32'hx;
      logic [31:0] gw = (i < acc_wgt.size()) ? acc_wgt[i] : 32'hx;
      logic [3:0]  gp = (i < acc_pe.size())  ? acc_pe[i]  : 4'hx;
      n_vec++;
      if (gi !== e_ifm[i] || gw !== e_wgt[i] || gp !== 4'b1111) begin
        n_err++;
        $display("FAIL basic_addr[%0d]: got ifm=%h wgt=%h en=%b want ifm=%h wgt=%h en=1111",
                 i, gi, gw, gp, e_ifm[i], e_wgt[i]);
      end
    end
    n_vec++;
    if (fin_q.size() !== 2 || (fin_q.size() == 2 && (fin_q[0] !== 4'hF || fin_q[1] !== 4'hF))) begin
      n_err++; $display("FAIL basic_finish: got %0d pulses want 2 x 1111", fin_q.size());
    end
    n_vec++;
    if (done_cyc !== 7) begin
      n_err++; $display("FAIL basic_done_cycle: got %0d want 7", done_cyc);
    end
    n_vec++;
    if (n_busy !== 6) begin
      n_err++; $display("FAIL basic_busy_cycles: got %0d want 6", n_busy);
    end
  endtask

  task automatic test_partial_group();
    logic [31:0] e_wgt[2] = '{32'h800, 32'h804};
    logic [3:0]  e_pe[2]  = '{4'b1111, 4'b0011};
    run_layer(16'd1, 16'd6, 16'd1, 32'h100, 32'h800, -1, 0, -1, 40);
    n_vec++;
    if (acc_ifm.size() !== 2) begin
      n_err++; $display("FAIL partial_count: got %0d want 2", acc_ifm.size());
    end
    for (int i = 0; i < 2; i++) begin
      logic [31:0] gi = (i < acc_ifm.size()) ? acc_ifm[i] : 32'hx;
      logic [31:0] gw = (i < acc_wgt.size()) ? acc_wgt[i] : 32'hx;
      logic [3:0]  gp = (i < acc_pe.size())  ? acc_pe[i]  : 4'hx;
      logic [3:0]  gf = (i < fin_q.size())   ? fin_q[i]   : 4'hx;
      n_vec++;
      if (gi !== 32'h100 || gw !== e_wgt[i] || gp !== e_pe[i] || gf !== e_pe[i]) begin
        n_err++;
        $display("FAIL partial[%0d]: got ifm=%h wgt=%h en=%b fin=%b want ifm=100 wgt=%h en=fin=%b",
                 i, gi, gw, gp, gf, e_wgt[i], e_pe[i]);
      end
    end
    n_vec++;
    if (done_cyc !== 5) begin
      n_err++; $display("FAIL partial_done_cycle: got %0d want 5", done_cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e_ifm[4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [31:0] e_wgt[4] = '{32'h800, 32'h804, 32'h800, 32'h804};
    run_layer(16'd2, 16'd4, 16'd2, 32'h100, 32'h800, 1, 3, -1, 40);
    n_vec++;
    if (stl_ifm.size() !== 3) begin
      n_err++; $display("FAIL stall_count: got %0d want 3", stl_ifm.size());
    end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] gi = (i < stl_ifm.size()) ? stl_ifm[i] : 32'hx;
      logic [31:0] gw = (i < stl_wgt.size()) ? stl_wgt[i] : 32'hx;
      logic [3:0]  gp = (i < stl_pe.size())  ? stl_pe[i]  : 4'hx;
      n_vec++;
      if (gi !== 32'h104 || gw !== 32'h804 || gp !== 4'b1111) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got ifm=%h wgt=%h en=%b want 104/804/1111", i, gi, gw, gp);
      end
    end
    n_vec++;
    if (acc_ifm.size() !== 4) begin
      n_err++; $display("FAIL stall_accept_count: got %0d want 4", acc_ifm.size());
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] gi = (i < acc_ifm.size()) ? acc_ifm[i] : 32'hx;
      logic [31:0] gw = (i < acc_wgt.size()) ? acc_wgt[i] : 32'hx;
      n_vec++;
      if (gi !== e_ifm[i] || gw !== e_wgt[i]) begin
        n_err++;
        $display("FAIL stall_seq[%0d]: got ifm=%h wgt=%h want ifm=%h wgt=%h", i, gi, gw, e_ifm[i], e_wgt[i]);
      end
    end
    n_vec++;
    if (done_cyc !== 10) begin
      n_err++; $display("FAIL stall_done_cycle: got %0d want 10", done_cyc);
    end
  endtask

  task automatic test_zero_config();
    run_layer(16'd2, 16'd4, 16'd0, 32'h100, 32'h800, -1, 0, -1, 20);
    n_vec++;
    if (done_cyc !== 1 || valid_seen !== 1'b0 || n_busy !== 0) begin
      n_err++;
      $display("FAIL zero_pixel: got done_cyc=%0d valid_seen=%b busy_cycles=%0d want 1/0/0",
               done_cyc, valid_seen, n_busy);
    end
    run_layer(16'd0, 16'd4, 16'd2, 32'h100, 32'h800, -1, 0, -1, 20);
    n_vec++;
    if (done_cyc !== 1 || valid_seen !== 1'b0) begin
      n_err++;
      $display("FAIL zero_ch: got done_cyc=%0d valid_seen=%b want 1/0", done_cyc, valid_seen);
    end
  endtask

  task automatic test_wrap();
    run_layer(16'd2, 16'd1, 16'd1, 32'hFFFF_FFFC, 32'h10, -1, 0, -1, 20);
    n_vec++;
    if (acc_ifm.size() !== 2 ||
        (acc_ifm.size() == 2 && (acc_ifm[0] !== 32'hFFFF_FFFC || acc_ifm[1] !== 32'h0 ||
                                 acc_wgt[0] !== 32'h10 || acc_wgt[1] !== 32'h14 ||
                                 acc_pe[0] !== 4'b0001))) begin
      n_err++;
      $display("FAIL wrap_addr: got %0d pairs, want FFFFFFFC/10, 00000000/14 with en=0001", acc_ifm.size());
    end
    n_vec++;
    if (fin_q.size() !== 1 || (fin_q.size() == 1 && fin_q[0] !== 4'b0001) || done_cyc !== 4) begin
      n_err++;
      $display("FAIL wrap_finish: got %0d pulses done_cyc=%0d want 1 x 0001, 4", fin_q.size(), done_cyc);
    end
  endtask

  task automatic test_reset_mid_layer();
    ifc.cfg_ch_words = 16'd2; ifc.cfg_num_filter = 16'd4; ifc.cfg_num_pixel = 16'd2;
    ifc.cfg_ifm_base = 32'h100; ifc.cfg_wgt_base = 32'h800;
    ifc.mem_ready = 1'b1; ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (ifc.addr_ifm !== 32'h108 || ifc.addr_valid !== 1'b1) begin
      n_err++; $display("FAIL midrst_pos: got ifm=%h v=%b want 108/1", ifc.addr_ifm, ifc.addr_valid);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({ifc.addr_ifm, ifc.addr_weight, ifc.addr_valid, ifc.PE_en, ifc.PE_finish,
         ifc.busy, ifc.done} !== 79'd0) begin
      n_err++;
      $display("FAIL midrst_outputs: got ifm=%h wgt=%h v=%b en=%b busy=%b want all 0",
               ifc.addr_ifm, ifc.addr_weight, ifc.addr_valid, ifc.PE_en, ifc.busy);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (ifc.busy !== 1'b0 || ifc.addr_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_no_resume: got busy=%b v=%b want 0/0", ifc.busy, ifc.addr_valid);
    end
    run_layer(16'd2, 16'd4, 16'd2, 32'h100, 32'h800, -1, 0, -1, 40);
    n_vec++;
    if (acc_ifm.size() !== 4 || (acc_ifm.size() == 4 && (acc_ifm[0] !== 32'h100 ||
        acc_wgt[0] !== 32'h800 || acc_ifm[3] !== 32'h10C)) || done_cyc !== 7) begin
      n_err++;
      $display("FAIL midrst_restart: got %0d pairs done_cyc=%0d want 4 from 100/800, 7",
               acc_ifm.size(), done_cyc);
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] e_ifm[4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [31:0] e_wgt[4] = '{32'h800, 32'h804, 32'h800, 32'h804};
    run_layer(16'd2, 16'd4, 16'd2, 32'h100, 32'h800, -1, 0, 2, 40);
    n_vec++;
    if (acc_ifm.size() !== 4 || done_cyc !== 7) begin
      n_err++;
      $display("FAIL busy_start_len: got %0d pairs done_cyc=%0d want 4, 7", acc_ifm.size(), done_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] gi = (i < acc_ifm.size()) ? acc_ifm[i] : 32'hx;
      logic [31:0] gw = (i < acc_wgt.size()) ? acc_wgt[i] : 32'hx;
      n_vec++;
      if (gi !== e_ifm[i] || gw !== e_wgt[i]) begin
        n_err++;
        $display("FAIL busy_start_seq[%0d]: got ifm=%h wgt=%h want ifm=%h wgt=%h", i, gi, gw, e_ifm[i], e_wgt[i]);
      end
    end
    n_vec++;
    if (ifc.busy !== 1'b0) begin
      n_err++; $display("FAIL busy_start_idle: got busy=%b want 0", ifc.busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_group();
    test_backpressure();
    test_zero_config();
    test_wrap();
    test_reset_mid_layer();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
